// File: rtl/adder_tb_pkg.sv
`default_nettype none
// ============================================================================
// Package     : adder_tb_pkg
// Description : Shared definitions for the pipelined adder, its result
//               checker and the bench: checker state encoding and the default
//               operand width / adder latency.
// Revision    : 1.0 - initial release
// ============================================================================
package adder_tb_pkg;

  // Checker run state; explicit 2-bit encoding
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DATA_WIDTH    = 3;  // adder operand width
  localparam int ADDER_LATENCY = 2;  // adder register stages (NUM_REG)

endpackage : adder_tb_pkg
`default_nettype wire

// File: rtl/adder_exp_delay.sv
`default_nettype none
// ============================================================================
// Module      : adder_exp_delay
// Description : DEPTH-stage shift register carrying {valid, golden sum}
//               words. The MSB of every word is that stage's valid bit.
//               Shifts every cycle; synchronous reset clears every stage
//               (so all valid bits drop to 0).
// Ports       : clk    in   rising-edge clock
//               rst    in   synchronous active-high reset
//               d_in   in   WIDTH  word entering stage 0
//               d_out  out  WIDTH  word leaving the last stage
// Revision    : 1.0 - initial release
// ============================================================================
module adder_exp_delay #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] d_out
);

  // Stage 0 occupies the low WIDTH bits; the oldest stage sits at the top.
  logic [DEPTH*WIDTH-1:0] r_sr;

  generate
    if (DEPTH == 1) begin : g_single
      always_ff @(posedge clk) begin
        if (rst) r_sr <= '0;
        else     r_sr <= d_in;
      end
    end else begin : g_multi
      always_ff @(posedge clk) begin
        if (rst) r_sr <= '0;
        else     r_sr <= {r_sr[(DEPTH-1)*WIDTH-1:0], d_in};
      end
    end
  endgenerate

  assign d_out = r_sr[DEPTH*WIDTH-1 -: WIDTH];

endmodule : adder_exp_delay
`default_nettype wire

// File: rtl/adder_result_checker.sv
`default_nettype none
// ============================================================================
// Module      : adder_result_checker
// Description : Checks the registered sum of pipelined_adder against a golden
//               sum built from the operands tapped at the adder input and
//               delayed LATENCY cycles. Runs a fixed number of checks per run,
//               counts passes/fails (saturating) and latches the first
//               mismatch.
// Ports       : clk, rst (sync, active high)
//               start           in   begin a run (IDLE/DONE only)
//               inp_valid       in   operands presented to the adder
//               inp1, inp2      in   INP_DW operands
//               dut_outp        in   INP_DW+1 adder result
//               busy, done      out  state decode (registered)
//               pass_cnt        out  CNT_W matching compares
//               fail_cnt        out  CNT_W mismatching compares
//               err_seen        out  a mismatch occurred this run
//               first_err_exp   out  golden sum of first mismatch
//               first_err_got   out  dut_outp at first mismatch
// Revision    : 1.0 - initial release
// ============================================================================
module adder_result_checker
  import adder_tb_pkg::*;
#(
  parameter int INP_DW     = DATA_WIDTH,
  parameter int LATENCY    = ADDER_LATENCY,  // 1..16
  parameter int NUM_CHECKS = 16,             // >= 1
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              inp_valid,
  input  logic [INP_DW-1:0] inp1,
  input  logic [INP_DW-1:0] inp2,
  input  logic [INP_DW:0]   dut_outp,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [CNT_W-1:0]  fail_cnt,
  output logic              err_seen,
  output logic [INP_DW:0]   first_err_exp,
  output logic [INP_DW:0]   first_err_got
);

  localparam int c_ACC_W = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS + 1) : 1;
  localparam int c_DRN_W = (LATENCY > 1) ? $clog2(LATENCY + 1) : 1;
  localparam logic [c_ACC_W-1:0] c_ACC_LAST = c_ACC_W'(NUM_CHECKS - 1);
  localparam logic [c_DRN_W-1:0] c_DRN_LAST = c_DRN_W'(LATENCY - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_ACC_W-1:0]   r_acc_cnt;
  logic [c_DRN_W-1:0]   r_drn_cnt;
  logic                 r_busy;
  logic                 r_done;
  logic [CNT_W-1:0]     r_pass_cnt;
  logic [CNT_W-1:0]     r_fail_cnt;
  logic                 r_err_seen;
  logic [INP_DW:0]      r_first_exp;
  logic [INP_DW:0]      r_first_got;

  logic                 w_push;
  logic                 w_last_push;
  logic                 w_start_run;
  logic [INP_DW:0]      w_exp;
  logic                 w_cmp_vld;
  logic [INP_DW:0]      w_cmp_exp;

  // Only operands accepted in RUN enter the delay line; elsewhere a bubble.
  assign w_push      = inp_valid && (r_state == RUN);
  assign w_last_push = w_push && (r_acc_cnt == c_ACC_LAST);
  assign w_start_run = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_exp       = {1'b0, inp1} + {1'b0, inp2};

  adder_exp_delay #(
    .WIDTH (INP_DW + 2),
    .DEPTH (LATENCY)
  ) u_exp_delay (
    .clk   (clk),
    .rst   (rst),
    .d_in  ({w_push, w_exp}),
    .d_out ({w_cmp_vld, w_cmp_exp})
  );

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start)       w_state_nxt = RUN;
      RUN:     if (w_last_push) w_state_nxt = DRAIN;
      // Leave DRAIN on the edge that performs the final compare, so the
      // first DONE cycle already shows the complete result.
      DRAIN:   if (r_drn_cnt == c_DRN_LAST) w_state_nxt = DONE;
      DONE:    if (start)       w_state_nxt = RUN;
      default:                  w_state_nxt = IDLE;
    endcase
  end

  // State, status and sequencing counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_acc_cnt <= '0;
      r_drn_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == RUN) || (w_state_nxt == DRAIN);
      r_done  <= (w_state_nxt == DONE);

      if (w_start_run)  r_acc_cnt <= '0;
      else if (w_push)  r_acc_cnt <= r_acc_cnt + c_ACC_W'(1);

      if (r_state != DRAIN) r_drn_cnt <= '0;
      else                  r_drn_cnt <= r_drn_cnt + c_DRN_W'(1);
    end
  end

  // Compare, saturating counters and first-error latch
  always_ff @(posedge clk) begin
    if (rst || w_start_run) begin
      r_pass_cnt  <= '0;
      r_fail_cnt  <= '0;
      r_err_seen  <= 1'b0;
      r_first_exp <= '0;
      r_first_got <= '0;
    end else if (w_cmp_vld) begin
      if (dut_outp == w_cmp_exp) begin
        if (r_pass_cnt != '1) r_pass_cnt <= r_pass_cnt + CNT_W'(1);
      end else begin
        if (r_fail_cnt != '1) r_fail_cnt <= r_fail_cnt + CNT_W'(1);
        if (!r_err_seen) begin
          r_err_seen  <= 1'b1;
          r_first_exp <= w_cmp_exp;
          r_first_got <= dut_outp;
        end
      end
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign pass_cnt      = r_pass_cnt;
  assign fail_cnt      = r_fail_cnt;
  assign err_seen      = r_err_seen;
  assign first_err_exp = r_first_exp;
  assign first_err_got = r_first_got;

endmodule : adder_result_checker
`default_nettype wire
